ccs_chan_fifo_v1: RTL and testbench

CCS_CHAN_FIFO_V1 -- requirements
Module: ccs_chan_fifo_v1

---
 rtl/ccs_chan_fifo_v1.sv | 71 +++++++
 tb/tb_ccs_chan_fifo_v1.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ccs_chan_fifo_v1.sv
// Channel FIFO with registered occupancy. din_rdy and dout_vld depend only on state,
// so there is no combinational path from one channel's handshake to the other's.
module ccs_chan_fifo_v1 #(
  parameter int unsigned rscid = 1,
  parameter int unsigned width = 8,
  parameter int unsigned depth = 4,
  localparam int unsigned aw   = $clog2(depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] din,
  input  logic             din_vld,
  output logic             din_rdy,
  output logic [width-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic [aw:0]      sz
);

  localparam logic [aw:0] full_cnt = (aw + 1)'(depth);

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr_q, wr_ptr_d;
  logic [aw-1:0]    rd_ptr_q, rd_ptr_d;
  logic [aw:0]      sz_q, sz_d;
  logic             push, pop;

  // rscid only binds the instance to a tool resource.
  logic unused_rscid;
  assign unused_rscid = ^rscid;

  assign din_rdy  = (sz_q != full_cnt);
  assign dout_vld = (sz_q != '0);
  assign dout     = mem[rd_ptr_q];
  assign sz       = sz_q;

  assign push = din_vld & din_rdy;
  assign pop  = dout_vld & dout_rdy;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    sz_d     = sz_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   sz_d = sz_q + 1'b1;
      2'b01:   sz_d = sz_q - 1'b1;
      default: sz_d = sz_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      sz_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      sz_q     <= sz_d;
    end
  end

  // Storage is deliberately unreset; a write in the reset cycle is harmless because
  // the pointers are cleared and the entry is invisible until rewritten.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr_q] <= din;
  end

endmodule

// File: tb/tb_ccs_chan_fifo_v1.sv
// Self-checking bench for ccs_chan_fifo_v1: directed corner cases plus a random stall
// run, all compared against a queue-based reference model.
module tb_ccs_chan_fifo_v1;

  localparam int unsigned width = 8;
  localparam int unsigned depth = 4;

  logic             clk;
  logic             rst;
  logic [width-1:0] din;
  logic             din_vld;
  logic             din_rdy;
  logic [width-1:0] dout;
  logic             dout_vld;
  logic             dout_rdy;
  logic [2:0]       sz;

  logic [width-1:0] model_q[$];
  int               n_checks;
  int               n_fail;

  ccs_chan_fifo_v1 #(
    .rscid(1),
    .width(width),
    .depth(depth)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .din_vld (din_vld),
    .din_rdy (din_rdy),
    .dout    (dout),
    .dout_vld(dout_vld),
    .dout_rdy(dout_rdy),
    .sz      (sz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, then advance both.
  task automatic cycle(input logic v, input logic [width-1:0] d, input logic r,
                       input logic rs);
    logic push, pop;
    din_vld  = v;
    din      = d;
    dout_rdy = r;
    rst      = rs;
    #1;
    check("sz", 32'(sz), 32'(model_q.size()));
    check("din_rdy", 32'(din_rdy), 32'(model_q.size() != depth));
    check("dout_vld", 32'(dout_vld), 32'(model_q.size() != 0));
    if (model_q.size() > 0) check("dout", 32'(dout), 32'(model_q[0]));
    push = !rs && v && (model_q.size() < depth);
    pop  = !rs && r && (model_q.size() > 0);
    @(posedge clk);
    #1;
    if (rs) begin
      model_q.delete();
    end else begin
      if (pop)  void'(model_q.pop_front());
      if (push) model_q.push_back(d);
    end
  endtask

  initial begin
    logic [width-1:0] fill_vals[4];
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    din      = '0;
    din_vld  = 1'b0;
    dout_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_q.delete();

    // Reset state
    check("rst_sz", 32'(sz), 32'd0);
    check("rst_din_rdy", 32'(din_rdy), 32'd1);
    check("rst_dout_vld", 32'(dout_vld), 32'd0);

    // Empty latency: pushed in cycle N, visible only in N+1
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    check("lat_vld", 32'(dout_vld), 32'd1);
    check("lat_dout", 32'(dout), 32'hA5);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("lat_empty", 32'(dout_vld), 32'd0);

    // Fill then drain in order
    fill_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) cycle(1'b1, fill_vals[i], 1'b0, 1'b0);
    check("fill_sz", 32'(sz), 32'd4);
    check("fill_rdy", 32'(din_rdy), 32'd0);
    cycle(1'b1, 8'h99, 1'b0, 1'b0);
    check("full_hold_sz", 32'(sz), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("drain_dout", 32'(dout), 32'(fill_vals[i]));
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("drain_sz", 32'(sz), 32'd0);
    check("drain_vld", 32'(dout_vld), 32'd0);

    // Full with simultaneous push attempt and pop: pop only
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h70, 1'b1, 1'b0);
    check("fullpop_sz", 32'(sz), 32'd3);
    check("fullpop_rdy", 32'(din_rdy), 32'd1);
    check("fullpop_dout", 32'(dout), 32'h61);
    cycle(1'b1, 8'h70, 1'b0, 1'b0);
    check("fullpush_sz", 32'(sz), 32'd4);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Wrap-around with steady occupancy of two
    cycle(1'b1, 8'hB0, 1'b0, 1'b0);
    cycle(1'b1, 8'hB1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
    check("wrap_sz", 32'(sz), 32'd2);
    check("wrap_dout", 32'(dout), 32'hC8);
    for (int i = 0; i < 2; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset mid-operation discards entries and suppresses push/pop
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0);
    check("pre_rst_sz", 32'(sz), 32'd3);
    cycle(1'b1, 8'hEE, 1'b1, 1'b1);
    check("mid_rst_sz", 32'(sz), 32'd0);
    check("mid_rst_vld", 32'(dout_vld), 32'd0);
    check("mid_rst_rdy", 32'(din_rdy), 32'd1);
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    check("post_rst_dout", 32'(dout), 32'h5A);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Random stalls on both sides
    for (int i = 0; i < 1000; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
